// File: rtl/decoder_pkg.sv
// Shared decode constants: opcode map, instruction field positions, control strobes.
package decoder_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_MOV   = 4'h4;
    localparam logic [3:0] OP_MOVR  = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_NOT   = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_LOAD  = 4'hA;
    localparam logic [3:0] OP_JUMP  = 4'hB;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int FA_MSB  = 11;
    localparam int FA_LSB  = 6;
    localparam int FB_MSB  = 5;
    localparam int FB_LSB  = 0;

    typedef struct packed {
        logic write;
        logic jump;
        logic mov;
        logic movReg;
        logic store;
        logic load;
        logic illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/inst_decoder_if.sv
// Decoder bus: instruction in, registered opcode/address/strobes out.
interface inst_decoder_if;

    logic [15:0] inst;
    logic [3:0]  op;
    logic [11:0] RegAddr;
    logic        write;
    logic        jump;
    logic        mov;
    logic        movReg;
    logic        store;
    logic        load;
    logic        illegal;

    // Instruction source / consumer of the decode.
    modport master (
        output inst,
        input  op, RegAddr, write, jump, mov, movReg, store, load, illegal
    );

    // The decoder itself.
    modport slave (
        input  inst,
        output op, RegAddr, write, jump, mov, movReg, store, load, illegal
    );

endinterface

// File: rtl/inst_decoder_decode_logic.sv
// Combinational opcode decode into ALU op and control strobes.
module decode_logic
    import decoder_pkg::*;
(
    input  logic [3:0] opc,
    output logic [3:0] op,
    output ctrl_t      ctrl
);

    // Opcode table; reserved opcodes flag illegal and forward a NOP op.
    always_comb begin
        op   = opc;
        ctrl = CTRL_NONE;
        unique case (opc)
            OP_NOP:   ;
            OP_ADD,
            OP_SUB,
            OP_AND,
            OP_OR,
            OP_XOR,
            OP_NOT:   ctrl.write = 1'b1;
            OP_MOV: begin
                ctrl.mov   = 1'b1;
                ctrl.write = 1'b1;
            end
            OP_MOVR: begin
                ctrl.movReg = 1'b1;
                ctrl.write  = 1'b1;
            end
            OP_STORE: ctrl.store = 1'b1;
            OP_LOAD: begin
                ctrl.load  = 1'b1;
                ctrl.write = 1'b1;
            end
            OP_JUMP:  ctrl.jump = 1'b1;
            default: begin
                op           = OP_NOP;
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_decoder.sv
// Instruction decoder top: one register stage on the decode, async active-high reset.
module inst_decoder
    import decoder_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    inst_decoder_if.slave  bus
);

    logic [3:0]  op_d;
    ctrl_t       ctrl_d;
    logic [3:0]  op_q;
    logic [11:0] addr_q;
    ctrl_t       ctrl_q;

    decode_logic u_decode (
        .opc  (bus.inst[OPC_MSB:OPC_LSB]),
        .op   (op_d),
        .ctrl (ctrl_d)
    );

    // Output register bank; address fields pass through for every opcode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            addr_q <= '0;
            ctrl_q <= CTRL_NONE;
        end else begin
            op_q   <= op_d;
            addr_q <= {bus.inst[FA_MSB:FA_LSB], bus.inst[FB_MSB:FB_LSB]};
            ctrl_q <= ctrl_d;
        end
    end

    assign bus.op      = op_q;
    assign bus.RegAddr = addr_q;
    assign bus.write   = ctrl_q.write;
    assign bus.jump    = ctrl_q.jump;
    assign bus.mov     = ctrl_q.mov;
    assign bus.movReg  = ctrl_q.movReg;
    assign bus.store   = ctrl_q.store;
    assign bus.load    = ctrl_q.load;
    assign bus.illegal = ctrl_q.illegal;

endmodule

// File: tb/tb_inst_decoder.sv
// Self-checking bench for inst_decoder: directed cases, then a randomized opcode sweep
// with an asynchronous reset pulse, compared against a table-driven reference model.
module tb_inst_decoder;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    inst_decoder_if bus ();

    inst_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Mnemonic per opcode; strobes are derived from the instruction class below.
    string mnem [16] = '{"NOP", "ADD", "SUB", "AND", "MOV", "MOVR", "OR", "XOR",
                         "NOT", "STORE", "LOAD", "JUMP", "RSV", "RSV", "RSV", "RSV"};

    // Observed vector: {op, RegAddr, write, jump, mov, movReg, store, load, illegal}
    function automatic logic [22:0] observed();
        return {bus.op, bus.RegAddr, bus.write, bus.jump, bus.mov, bus.movReg,
                bus.store, bus.load, bus.illegal};
    endfunction

    function automatic logic [22:0] model(input logic [15:0] i);
        int    opc;
        string m;
        logic  wr, jp, mv, mr, st, ld, il;
        logic [3:0] o;
        opc = int'(i[15:12]);
        m   = mnem[opc];
        il  = (m == "RSV");
        o   = il ? 4'd0 : i[15:12];
        jp  = (m == "JUMP");
        mv  = (m == "MOV");
        mr  = (m == "MOVR");
        st  = (m == "STORE");
        ld  = (m == "LOAD");
        // Everything that lands a value in register A writes the register file.
        wr  = (m == "ADD") || (m == "SUB") || (m == "AND") || (m == "OR") ||
              (m == "XOR") || (m == "NOT") || mv || mr || ld;
        return {o, i[11:0], wr, jp, mv, mr, st, ld, il};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Structural rules that must hold on every observed cycle.
    task automatic chk_rules(input string tag);
        int n_onehot;
        n_onehot = int'(bus.jump) + int'(bus.mov) + int'(bus.movReg) +
                   int'(bus.store) + int'(bus.load);
        chk({tag, ".onehot"}, 32'(n_onehot <= 1), 32'd1);
        chk({tag, ".wexcl"}, 32'(bus.write & (bus.store | bus.jump)), 32'd0);
    endtask

    // Present v from a negedge, check the registered decode at the following negedge.
    task automatic apply(input string tag, input logic [15:0] v);
        bus.inst = v;
        @(posedge clk);
        @(negedge clk);
        chk(tag, 32'(observed()), 32'(model(v)));
        chk_rules(tag);
    endtask

    // Called at a negedge: pulse reset between edges, outputs must clear at once
    // and stay clear after release until the next edge.
    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, ".async"}, 32'(observed()), 32'd0);
        #1;
        rst = 1'b0;
        #1;
        chk({tag, ".hold"}, 32'(observed()), 32'd0);
    endtask

    initial begin
        logic [15:0] v;
        n_vec    = 0;
        n_bad    = 0;
        clk      = 1'b0;
        rst      = 1'b1;
        bus.inst = 16'hFFFF;

        // Reset state with no clock edge yet.
        #2;
        chk("rst.async", 32'(observed()), 32'd0);
        rst = 1'b0;
        #2;
        chk("rst.hold", 32'(observed()), 32'd0);
        @(negedge clk);
        chk("rst.first_edge", 32'(observed()), 32'(model(16'hFFFF)));

        apply("add",   16'b0001_000000_000000);
        chk("add.write", 32'(bus.write), 32'd1);
        apply("mov",   16'b0100_000000_000001);
        chk("mov.strobes", 32'({bus.mov, bus.write}), 32'b11);
        apply("movr",  16'b0101_000000_000001);
        chk("movr.strobes", 32'({bus.movReg, bus.mov, bus.write}), 32'b101);
        apply("store", 16'b1001_000000_000001);
        chk("store.strobes", 32'({bus.store, bus.write}), 32'b10);
        apply("load",  16'b1010_000000_000001);
        chk("load.op", 32'(bus.op), 32'hA);
        apply("jump",  16'b1011_000011_000101);
        chk("jump.addr", 32'(bus.RegAddr), 32'h0C5);
        apply("rsv",   16'hC123);
        chk("rsv.fields", 32'({bus.illegal, bus.op, bus.RegAddr}), 32'h10123);

        // Opcode sweep with random fields and a reset pulse partway through.
        for (int rep = 0; rep < 4; rep++) begin
            for (int o = 0; o < 16; o++) begin
                v = {o[3:0], 12'($urandom)};
                apply($sformatf("sweep.%s", mnem[o]), v);
                if (rep == 1 && o == 7)
                    reset_pulse("sweep.rst");
            end
        end

        // Fully random instructions.
        for (int k = 0; k < 60; k++) begin
            v = 16'($urandom);
            apply("rand", v);
        end

        // Reset after an illegal decode as well.
        apply("pre_rst", 16'hF000);
        reset_pulse("end.rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Absolute guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary, expected finish");
        $fatal(1);
    end

endmodule
